// File: rtl/logic_pipe_pkg.sv
// Shared definitions for logic_pipe: operation codes and the op-select width.
package logic_pipe_pkg;

    localparam int LP_OP_W = 3;

    typedef enum logic [LP_OP_W-1:0] {
        LP_AND     = 3'd0,
        LP_INHIBIT = 3'd1,
        LP_OR      = 3'd2,
        LP_XOR     = 3'd3,
        LP_NAND    = 3'd4,
        LP_NOR     = 3'd5,
        LP_XNOR    = 3'd6,
        LP_PASSB   = 3'd7
    } lp_op_e;

endpackage

// File: rtl/logic_core.sv
// Combinational bitwise operation unit feeding the logic_pipe stage registers.
module logic_core
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [LP_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   r
);

    always_comb begin
        r = '0;
        case (op)
            LP_AND:     r = a & b;
            LP_INHIBIT: r = ~a & b;
            LP_OR:      r = a | b;
            LP_XOR:     r = a ^ b;
            LP_NAND:    r = ~(a & b);
            LP_NOR:     r = ~(a | b);
            LP_XNOR:    r = ~(a ^ b);
            LP_PASSB:   r = b;
            default:    r = '0;
        endcase
    end

endmodule

// File: rtl/logic_pipe.sv
// Bitwise logic unit with a registered output stage and a one-entry skid buffer.
// Define LOGIC_PIPE_STATS_EN to build the saturating op_count transfer counter.
module logic_pipe
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LP_OP_W-1:0]   op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     s,
    output logic                 zero,
    output logic [CNT_W-1:0]     op_count
);

    logic [WIDTH-1:0] r_p0;
    logic [WIDTH-1:0] skid_p1;
    logic             skid_vld_p1;
    logic [WIDTH-1:0] s_p2;
    logic             vld_p2;
    logic             rdy_q;
    logic             accept;
    logic             drain;

    logic_core #(.WIDTH(WIDTH)) u_core (
        .op (op),
        .a  (a),
        .b  (b),
        .r  (r_p0)
    );

    assign accept = in_valid && rdy_q;
    assign drain  = vld_p2 && out_ready;

    // ---- stage p1/p2: output register and skid control; in_ready mirrors !skid_vld_p1 from a flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_q       <= 1'b1;
            s_p2        <= '0;
        end else begin
            if (drain && skid_vld_p1) begin
                s_p2        <= skid_p1;
                skid_vld_p1 <= 1'b0;
                rdy_q       <= 1'b1;
            end else if (accept && (!vld_p2 || drain)) begin
                s_p2   <= r_p0;
                vld_p2 <= 1'b1;
            end else if (accept) begin
                skid_vld_p1 <= 1'b1;
                rdy_q       <= 1'b0;
            end else if (drain) begin
                vld_p2 <= 1'b0;
            end
        end
    end

    // Skid payload is qualified by skid_vld_p1, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept && vld_p2 && !drain && !skid_vld_p1) begin
            skid_p1 <= r_p0;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_p2;
    assign s         = s_p2;
    assign zero      = (s_p2 == '0);

`ifdef LOGIC_PIPE_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (drain) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign op_count = cnt_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe: an 8-bit instance for function/flow control and a 1-bit, CNT_W=4 instance for the sweep and counter saturation.
module tb_logic_pipe;

`ifdef LOGIC_PIPE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        iv1, ir1, ov1, or1, z1;
    logic [2:0]  op1;
    logic [7:0]  a1, b1, s1;
    logic [15:0] cnt1;

    logic        iv2, ir2, ov2, or2, z2;
    logic [2:0]  op2;
    logic [0:0]  a2, b2, s2;
    logic [3:0]  cnt2;

    logic_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .op(op1),
        .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .s(s1), .zero(z1),
        .op_count(cnt1)
    );

    logic_pipe #(.WIDTH(1), .CNT_W(4)) dut_n (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .op(op2),
        .a(a2), .b(b2), .out_valid(ov2), .out_ready(or2), .s(s2), .zero(z2),
        .op_count(cnt2)
    );

    logic [7:0] q1[$];
    logic [0:0] q2[$];
    int n_vec = 0;
    int n_bad = 0;
    int tr1 = 0;
    int tr2 = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && ov1 && or1) begin
            tr1++;
            if (q1.size() == 0) begin
                check("unexpected_result", 64'(s1), 64'hDEAD);
            end else begin
                logic [7:0] e;
                e = q1.pop_front();
                check("result", 64'(s1), 64'(e));
                check("zero", 64'(z1), 64'(e == 8'h00));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && ov2 && or2) begin
            tr2++;
            if (q2.size() == 0) begin
                check("unexpected_result_n", 64'(s2), 64'hDEAD);
            end else begin
                logic [0:0] e;
                e = q2.pop_front();
                check("result_n", 64'(s2), 64'(e));
                check("zero_n", 64'(z2), 64'(e == 1'b0));
            end
        end
    end

    // Offer one pair and return just after the edge that accepted it; in_valid stays high.
    task automatic offer1(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic [7:0] e);
        bit done;
        done = 1'b0;
        op1 = o; a1 = x; b1 = y; iv1 = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ir1) begin
                q1.push_back(e);
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check("offer_timeout", 64'(ir1), 64'(1));
    endtask

    task automatic offer2(input logic [2:0] o, input logic x, input logic y, input logic e);
        bit done;
        done = 1'b0;
        op2 = o; a2 = x; b2 = y; iv2 = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ir2) begin
                q2.push_back(e);
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check("offer_timeout_n", 64'(ir2), 64'(1));
    endtask

    task automatic drain1();
        for (int i = 0; i < 50 && q1.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        if (q1.size() != 0) check("drain_timeout", 64'(q1.size()), 64'(0));
    endtask

    task automatic drain2();
        for (int i = 0; i < 50 && q2.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        if (q2.size() != 0) check("drain_timeout_n", 64'(q2.size()), 64'(0));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        q1.delete();
        q2.delete();
        @(negedge clk);
        reset = 1'b0;
        tr1 = 0;
        tr2 = 0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return ~x & y;
            3'd2: return x | y;
            3'd3: return x ^ y;
            3'd4: return ~(x & y);
            3'd5: return ~(x | y);
            3'd6: return ~(x ^ y);
            default: return y;
        endcase
    endfunction

    typedef struct { logic [2:0] o; logic [7:0] x; logic [7:0] y; logic [7:0] e; } vec_t;
    typedef struct { logic [2:0] o; logic x; logic y; logic e; } vec1_t;

    vec_t  vtab[8];
    vec1_t btab[8];

    initial begin
        vtab[0] = '{3'd0, 8'hAA, 8'h55, 8'h00};
        vtab[1] = '{3'd1, 8'h0F, 8'hFF, 8'hF0};
        vtab[2] = '{3'd2, 8'hA0, 8'h0C, 8'hAC};
        vtab[3] = '{3'd3, 8'h3C, 8'h0F, 8'h33};
        vtab[4] = '{3'd4, 8'hF0, 8'h3C, 8'hCF};
        vtab[5] = '{3'd5, 8'h81, 8'h02, 8'h7C};
        vtab[6] = '{3'd6, 8'h5A, 8'hA5, 8'h00};
        vtab[7] = '{3'd7, 8'h12, 8'h34, 8'h34};
        btab[0] = '{3'd0, 1'b0, 1'b0, 1'b0};
        btab[1] = '{3'd0, 1'b0, 1'b1, 1'b0};
        btab[2] = '{3'd0, 1'b1, 1'b0, 1'b0};
        btab[3] = '{3'd0, 1'b1, 1'b1, 1'b1};
        btab[4] = '{3'd1, 1'b0, 1'b0, 1'b0};
        btab[5] = '{3'd1, 1'b0, 1'b1, 1'b1};
        btab[6] = '{3'd1, 1'b1, 1'b0, 1'b0};
        btab[7] = '{3'd1, 1'b1, 1'b1, 1'b0};

        reset = 1'b1;
        iv1 = 1'b0; op1 = '0; a1 = '0; b1 = '0; or1 = 1'b1;
        iv2 = 1'b0; op2 = '0; a2 = '0; b2 = '0; or2 = 1'b1;
        #1;
        check("reset_out_valid", 64'(ov1), 64'(0));
        check("reset_in_ready", 64'(ir1), 64'(1));
        check("reset_s", 64'(s1), 64'(0));
        check("reset_zero", 64'(z1), 64'(1));
        check("reset_op_count", 64'(cnt1), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single INHIBIT with one-cycle latency.
        offer1(3'd1, 8'h0F, 8'hFF, 8'hF0);
        iv1 = 1'b0;
        check("latency_out_valid", 64'(ov1), 64'(1));
        check("latency_s", 64'(s1), 64'(8'hF0));
        drain1();

        // All eight operations back to back.
        foreach (vtab[i]) offer1(vtab[i].o, vtab[i].x, vtab[i].y, vtab[i].e);
        iv1 = 1'b0;
        drain1();

        // Backpressure: two accepted, third held off until the consumer drains.
        or1 = 1'b0;
        offer1(3'd3, 8'h3C, 8'h0F, 8'h33);
        check("bp_ready_after_first", 64'(ir1), 64'(1));
        offer1(3'd2, 8'hA0, 8'h0C, 8'hAC);
        op1 = 3'd4; a1 = 8'hF0; b1 = 8'h3C; iv1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_low", 64'(ir1), 64'(0));
            check("bp_hold_valid", 64'(ov1), 64'(1));
            check("bp_hold_s", 64'(s1), 64'(8'h33));
        end
        @(posedge clk);
        #1;
        or1 = 1'b1;
        offer1(3'd4, 8'hF0, 8'h3C, 8'hCF);
        iv1 = 1'b0;
        drain1();
        check("bp_ready_restored", 64'(ir1), 64'(1));

        // Asynchronous reset with both stages full.
        or1 = 1'b0;
        offer1(3'd5, 8'h81, 8'h02, 8'h7C);
        offer1(3'd6, 8'h5A, 8'hA5, 8'h00);
        iv1 = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_out_valid", 64'(ov1), 64'(0));
        check("async_in_ready", 64'(ir1), 64'(1));
        check("async_op_count", 64'(cnt1), 64'(0));
        check("async_zero", 64'(z1), 64'(1));
        q1.delete();
        @(negedge clk);
        reset = 1'b0;
        tr1 = 0;
        @(posedge clk);
        #1;
        or1 = 1'b1;
        offer1(3'd7, 8'h12, 8'h34, 8'h34);
        iv1 = 1'b0;
        check("post_reset_latency", 64'(ov1), 64'(1));
        drain1();

        // Streaming: 100 accepts in 100 cycles, 100 results.
        pulse_reset();
        begin
            int c0;
            c0 = cyc;
            for (int i = 0; i < 100; i++) begin
                logic [2:0] o;
                logic [7:0] x, y;
                o = 3'(i % 8);
                x = 8'(i * 7);
                y = 8'(8'hC3 ^ i);
                offer1(o, x, y, ref_op(o, x, y));
            end
            check("stream_cycles", 64'(cyc - c0), 64'(100));
        end
        iv1 = 1'b0;
        drain1();
        check("stream_results", 64'(tr1), 64'(100));
        check("stream_op_count", 64'(cnt1), STATS ? 64'(100) : 64'(0));

        // 1-bit sweep followed by counter saturation on the CNT_W=4 instance.
        foreach (btab[i]) offer2(btab[i].o, btab[i].x, btab[i].y, btab[i].e);
        for (int i = 0; i < 12; i++) offer2(3'd7, 1'b0, 1'b1, 1'b1);
        iv2 = 1'b0;
        drain2();
        check("sat_transfers", 64'(tr2), 64'(20));
        check("sat_op_count", 64'(cnt2), STATS ? 64'(15) : 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
